// File: rtl/alu_sequencer.sv
// Control sequencer for a bus-based datapath: decodes a latched instruction and
// steps through T3..T6 producing one-hot register and ALU enables.
module alu_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] ir,
    output logic [15:0] rout,
    output logic [15:0] rin,
    output logic        RYin,
    output logic        RYout,
    output logic        RZin,
    output logic        RZLOout,
    output logic        RZHIout,
    output logic        HIin,
    output logic        LOin,
    output logic [4:0]  ops,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T3   = 3'd1,
        S_T4   = 3'd2,
        S_T5   = 3'd3,
        S_T6   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        C_ILLEGAL = 2'd0,
        C_BINARY  = 2'd1,
        C_WIDE    = 2'd2,
        C_UNARY   = 2'd3
    } op_class_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    function automatic op_class_t classify(input logic [4:0] opc);
        op_class_t c;
        case (opc)
            OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR:          c = C_BINARY;
            OP_MUL, OP_DIV:                         c = C_WIDE;
            OP_NEG, OP_NOT:                         c = C_UNARY;
            default:                                c = C_ILLEGAL;
        endcase
        return c;
    endfunction

    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        logic [15:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Only opcode and the three register fields are kept; ir[14:0] carries
    // nothing this sequencer needs.
    logic        ir_unused;
    assign ir_unused = ^ir[14:0];

    state_t      state_q, state_d;
    logic [16:0] instr_q, instr_d;
    logic        illegal_q, illegal_d;

    logic [4:0]  opc_q;
    logic [3:0]  ra_q, rb_q, rc_q;
    op_class_t   cls_q;

    assign opc_q = instr_q[16:12];
    assign ra_q  = instr_q[11:8];
    assign rb_q  = instr_q[7:4];
    assign rc_q  = instr_q[3:0];
    assign cls_q = classify(opc_q);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        illegal_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    instr_d = ir[31:15];
                    case (classify(ir[31:27]))
                        C_BINARY, C_WIDE: state_d = S_T3;
                        C_UNARY:          state_d = S_T4;
                        default: begin
                            state_d   = S_IDLE;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
            end
            S_T3:    state_d = S_T4;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = (cls_q == C_WIDE) ? S_T6 : S_DONE;
            S_T6:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore decode: everything below depends only on state_q and instr_q.
    always_comb begin
        rout    = '0;
        rin     = '0;
        RYin    = 1'b0;
        RYout   = 1'b0;
        RZin    = 1'b0;
        RZLOout = 1'b0;
        RZHIout = 1'b0;
        HIin    = 1'b0;
        LOin    = 1'b0;
        ops     = '0;
        done    = 1'b0;
        busy    = (state_q != S_IDLE);
        illegal = illegal_q;
        case (state_q)
            S_T3: begin
                rout = onehot16(rb_q);
                RYin = 1'b1;
            end
            S_T4: begin
                RZin = 1'b1;
                ops  = opc_q;
                if (cls_q == C_UNARY) begin
                    rout = onehot16(rb_q);
                end else begin
                    rout  = onehot16(rc_q);
                    RYout = 1'b1;
                end
            end
            S_T5: begin
                RZLOout = 1'b1;
                if (cls_q == C_WIDE) LOin = 1'b1;
                else                 rin  = onehot16(ra_q);
            end
            S_T6: begin
                RZHIout = 1'b1;
                HIin    = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Port clock, input, 1: single clock; all state changes on rising edge.
REQ-002 Port clear, input, 1: asynchronous, active-low reset.
REQ-003 Port start, input, 1: request to execute the instruction on ir; sampled only in IDLE.
REQ-004 Port ir, input, 32: instruction. opcode=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15].
REQ-005 Port rout, output, 16: one-hot general-register bus-drive enables (bit n = Rn out).
REQ-006 Port rin, output, 16: one-hot general-register load enables (bit n = Rn in).
REQ-007 Port RYin, output, 1: load RY from bus.
REQ-008 Port RYout, output, 1: RY presented to ALU A input.
REQ-009 Port RZin, output, 1: load 64-bit RZ from ALU.
REQ-010 Port RZLOout / RZHIout, output, 1 each: drive RZ[31:0] / RZ[63:32] onto bus.
REQ-011 Port HIin / LOin, output, 1 each: load HI / LO from bus.
REQ-012 Port ops, output, 5: ALU operation code.
REQ-013 Port busy, output, 1: high in every state except IDLE.
REQ-014 Port done, output, 1: one-cycle completion pulse.
REQ-015 Port illegal, output, 1: one-cycle pulse on an unsupported opcode.

Function
REQ-016 Opcode table SHALL be: ADD 00011, SUB 00100, SHR 00101, SHRA 00110, SHL 00111, ROR 01000, ROL 01001, AND 01010, OR 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010.
- ADD through OR are binary; MUL and DIV are wide; NEG and NOT are unary.
- All other opcodes are illegal.
REQ-017 States SHALL be IDLE, T3, T4, T5, T6, DONE; each non-IDLE state lasts exactly one clock.
REQ-018 On a rising edge in IDLE with start=1, ir SHALL be latched internally; later changes on ir SHALL NOT affect the operation.
REQ-019 Transitions from IDLE on an accepted start SHALL be:
- binary/wide opcode -> T3;
- unary opcode -> T4;
- illegal opcode -> IDLE, with illegal=1 for the next cycle.
REQ-020 T3 SHALL assert rout[rb] and RYin; next state T4.
REQ-021 T4 SHALL assert RZin and ops=opcode.
- Binary/wide: also rout[rc] and RYout.
- Unary: also rout[rb], with RYout=0.
- Next state T5.
REQ-022 T5 SHALL assert RZLOout.
- Binary/unary: also rin[ra]; next state DONE.
- Wide: also LOin; next state T6.
REQ-023 T6 (wide only) SHALL assert RZHIout and HIin; next state DONE.
REQ-024 DONE SHALL assert done=1; next state IDLE.
REQ-025 Latency from the accepting edge to the done cycle SHALL be: binary 4 cycles, wide 5, unary 3.
REQ-026 Outputs SHALL be Moore outputs decoded from state and latched ir only; none combinationally depends on start or live ir.
REQ-027 At most one bit of rout and at most one bit of rin SHALL be high in any cycle; outputs not listed for a state SHALL be 0.
REQ-028 ops SHALL be 00000 in every state except T4.
REQ-029 start while busy=1 SHALL be ignored and neither queued nor latched.
- start held high through DONE is accepted on the first IDLE edge, giving back-to-back operations with one IDLE cycle between them.
REQ-030 Register index 0 SHALL be handled like any other index (rout[0]/rin[0]); no special-casing.

Reset
REQ-031 clear=0 SHALL immediately, without waiting for a clock edge, force state IDLE, internal ir to 0, and all outputs to 0, including busy, done and illegal.
REQ-032 Assertion of clear mid-operation (T3 to DONE) SHALL abort the operation; no subsequent rin, HIin or LOin pulse is generated for it.
REQ-033 After clear deasserts, the first accepted start SHALL behave as in REQ-019.

Verification
REQ-034 Binary: ir opcode=00101 (SHR), ra=1, rb=2, rc=3, start pulse. Required response:
- T3: rout=0x0004, RYin=1.
- T4: rout=0x0008, RYout=1, RZin=1, ops=00101.
- T5: RZLOout=1, rin=0x0002.
- Next cycle: done=1.
REQ-035 Wide: MUL, rb=4, rc=5. Required response:
- T5: RZLOout=1, LOin=1, rin=0.
- T6: RZHIout=1, HIin=1.
- done on the 5th cycle after acceptance.
REQ-036 Unary and illegal:
- NOT with rb=7, ra=8: T4 rout=0x0080, RYout=0; T5 rin=0x0100; done on the 3rd cycle.
- Opcode 11111: illegal=1 for one cycle, busy stays 0, all enables stay 0.
REQ-037 Busy handling: pulse start again with a different ir during T4 -> ignored; the original operation completes unchanged and the bus enables match the first ir.
REQ-038 Reset mid-operation: drive clear=0 asynchronously mid-T4 -> all outputs 0 before the next edge, state IDLE; after release, a fresh ADD completes normally.
